uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  UART transmit controller. Sits directly upstream of the TX line output mux and drives its 2-bit select.
//  - Accepts a parallel byte with a valid strobe and frames it as start / data (LSB first) / optional parity / stop.
//  - Serialises the data bits, computes the parity bit and drives the mux select per bit period.
//  - Reports busy for the whole frame.
//  - One CLK cycle equals one bit period (CLK is the baud-rate clock).
// PARAMETERS
//  DATA_WIDTH   8   number of data bits per frame
// PORTS
//  CLK        in   1           baud-rate clock, rising edge
//  RST        in   1           asynchronous reset, active low
//  P_DATA     in   DATA_WIDTH  parallel data to transmit
//  DATA_VALID in   1           P_DATA valid strobe, sampled on rising CLK
//  PAR_EN     in   1           1 = insert parity bit
//  PAR_TYP    in   1           0 = even parity, 1 = odd parity
//  mux_sel    out  2           00 start(0), 01 stop/idle(1), 10 ser_data, 11 par_bit
//  ser_data   out  1           current data bit (bit 0 of shift register)
//  par_bit    out  1           parity bit of latched frame
//  busy       out  1           1 from START through STOP inclusive
// BEHAVIOUR
//  Reset: RST low asynchronously forces the following; all outputs are registered or Moore-decoded from state.
//   - state = IDLE, mux_sel = 01, ser_data = 0, par_bit = 0, busy = 0
//   - shift register = 0, bit counter = 0
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//  IDLE:
//   - mux_sel = 01, busy = 0.
//   - If DATA_VALID = 1 at an edge: latch P_DATA, PAR_EN and PAR_TYP, compute par_bit, then go to START.
//  Parity value:
//   - Even: par_bit = ^P_DATA.
//   - Odd: par_bit = ~^P_DATA.
//   - Computed once at latch; held until the next latch.
//  START:
//   - mux_sel = 00, busy = 1.
//   - Next state: DATA, with counter = 0.
//  DATA:
//   - mux_sel = 10.
//   - Each cycle presents shift register bit 0 on ser_data, then shifts right.
//   - Counter runs 0..DATA_WIDTH-1.
//   - At counter = DATA_WIDTH-1: go to PARITY if latched PAR_EN = 1, else STOP.
//  PARITY:
//   - mux_sel = 11, for one cycle.
//   - Next state: STOP.
//  STOP:
//   - mux_sel = 01, busy = 1, for one cycle.
//   - If DATA_VALID = 1 in this cycle: latch the new byte and go straight to START (back-to-back, no idle gap).
//   - Otherwise go to IDLE.
//  Frame length: 1 + DATA_WIDTH + PAR_EN + 1 cycles (11 for 8 bits with parity, 10 without).
//  Latency:
//   - First START cycle on mux_sel is 1 cycle after DATA_VALID is sampled in IDLE.
//   - The downstream registered mux adds 1 more cycle to the line.
//  Input rules:
//   - DATA_VALID is ignored in START, DATA and PARITY.
//   - P_DATA, PAR_EN and PAR_TYP changes mid-frame have no effect on the current frame.
//  Counter width: $clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1.
//  Reset mid-frame: immediate return to IDLE with reset values; the frame is aborted and the line returns to idle-high.
//  No illegal state persists: unused encodings go to IDLE.
// TESTING
//  1. P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID
//     -> mux_sel 00, eight 10 cycles with ser_data 1,0,1,0,0,1,0,1, then 11 with par_bit=0, then 01; busy high 11 cycles.
//  2. Same as 1 with PAR_TYP=1 -> par_bit=1; PAR_EN=0 -> no 11 cycle, busy high 10 cycles.
//  3. DATA_VALID held high continuously with 8'h3C then 8'hC3 (second byte presented during STOP)
//     -> STOP of frame 1 is followed immediately by START of frame 2, no IDLE cycle.
//  4. DATA_VALID pulsed and P_DATA changed during DATA
//     -> current frame bits unchanged; no restart; busy stays high.
//  5. RST low during 4th data bit
//     -> same cycle: mux_sel=01, busy=0, ser_data=0; after release, the next DATA_VALID starts a clean frame.
//  6. Reset release with DATA_VALID=0 for 20 cycles -> mux_sel stays 01, busy stays 0.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel byte as start / data (LSB first) /
// optional parity / stop and drives the TX line mux select, one bit per CLK.
module uart_tx_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START = 2'b00;
    localparam logic [1:0] SEL_IDLE  = 2'b01;
    localparam logic [1:0] SEL_DATA  = 2'b10;
    localparam logic [1:0] SEL_PAR   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic                  par_en_q;
    logic                  par_en_next;
    logic                  par_bit_next;
    logic [1:0]            mux_sel_next;
    logic                  busy_next;
    logic                  accept;

    // Next-state, frame latch and Moore output decode of the upcoming state
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        cnt_next     = cnt;
        par_en_next  = par_en_q;
        par_bit_next = par_bit;
        mux_sel_next = SEL_IDLE;
        busy_next    = 1'b0;
        accept       = 1'b0;

        case (state)
            S_IDLE: begin
                if (DATA_VALID) begin
                    accept     = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                cnt_next   = '0;
                state_next = S_DATA;
            end
            S_DATA: begin
                shreg_next = shreg >> 1;
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_PARITY: begin
                state_next = S_STOP;
            end
            S_STOP: begin
                // A byte offered during STOP chains straight into the next frame
                if (DATA_VALID) begin
                    accept     = 1'b1;
                    state_next = S_START;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                shreg_next = '0;
                cnt_next   = '0;
            end
        endcase

        if (accept) begin
            shreg_next   = P_DATA;
            par_en_next  = PAR_EN;
            par_bit_next = PAR_TYP ? ~^P_DATA : ^P_DATA;
        end

        case (state_next)
            S_START: begin
                mux_sel_next = SEL_START;
                busy_next    = 1'b1;
            end
            S_DATA: begin
                mux_sel_next = SEL_DATA;
                busy_next    = 1'b1;
            end
            S_PARITY: begin
                mux_sel_next = SEL_PAR;
                busy_next    = 1'b1;
            end
            S_STOP: begin
                mux_sel_next = SEL_IDLE;
                busy_next    = 1'b1;
            end
            default: begin
                mux_sel_next = SEL_IDLE;
                busy_next    = 1'b0;
            end
        endcase
    end

    // State and registered outputs; mux_sel/busy always track the current state
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= S_IDLE;
            shreg    <= '0;
            cnt      <= '0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
            mux_sel  <= SEL_IDLE;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            shreg    <= shreg_next;
            cnt      <= cnt_next;
            par_en_q <= par_en_next;
            par_bit  <= par_bit_next;
            mux_sel  <= mux_sel_next;
            busy     <= busy_next;
        end
    end

    assign ser_data = shreg[0];

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table of frames plus hand sequences for back-to-back,
// mid-frame input changes and reset abort; per-cycle expectations via a scoreboard queue.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_en;
    logic       par_typ;
    logic [1:0] mux_sel;
    logic       ser_data;
    logic       par_bit;
    logic       busy;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK        (clk),
        .RST        (rst),
        .P_DATA     (p_data),
        .DATA_VALID (data_valid),
        .PAR_EN     (par_en),
        .PAR_TYP    (par_typ),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       chk_ser;
        logic       ser;
        logic       chk_par;
        logic       par;
        logic       bsy;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        logic       exp_par;
        int         exp_len;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference frame model: queue one expectation per bit period
    task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt, input bit add_idle);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = logic'(ones % 2) ^ pt;
        exp_q.push_back('{sel: 2'b00, chk_ser: 1'b0, ser: 1'b0, chk_par: 1'b1, par: p, bsy: 1'b1});
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{sel: 2'b10, chk_ser: 1'b1, ser: d[i], chk_par: 1'b1, par: p, bsy: 1'b1});
        if (pe)
            exp_q.push_back('{sel: 2'b11, chk_ser: 1'b0, ser: 1'b0, chk_par: 1'b1, par: p, bsy: 1'b1});
        exp_q.push_back('{sel: 2'b01, chk_ser: 1'b0, ser: 1'b0, chk_par: 1'b1, par: p, bsy: 1'b1});
        if (add_idle)
            exp_q.push_back('{sel: 2'b01, chk_ser: 1'b0, ser: 1'b0, chk_par: 1'b1, par: p, bsy: 1'b0});
    endtask

    // Advance one bit period and compare against the oldest queued expectation
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_mux_sel", 8'(mux_sel), 8'(e.sel));
            check("sb_busy", 8'(busy), 8'(e.bsy));
            if (e.chk_ser) check("sb_ser_data", 8'(ser_data), 8'(e.ser));
            if (e.chk_par) check("sb_par_bit", 8'(par_bit), 8'(e.par));
        end
    endtask

    task automatic run_frame(input vec_t v);
        int  busy_cnt;
        bit  done;
        p_data     = v.data;
        par_en     = v.pe;
        par_typ    = v.pt;
        data_valid = 1'b1;
        push_frame(v.data, v.pe, v.pt, 1'b1);
        step();
        data_valid = 1'b0;
        check("tbl_par_bit", 8'(par_bit), 8'(v.exp_par));
        busy_cnt = busy ? 1 : 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            step();
            if (busy) busy_cnt++;
            else      done = 1'b1;
        end
        if (!done) check("tbl_busy_timeout", 8'(1), 8'(0));
        check("tbl_busy_len", 8'(busy_cnt), 8'(v.exp_len));
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{data: 8'hA5, pe: 1'b1, pt: 1'b0, exp_par: 1'b0, exp_len: 11};
        vecs[1] = '{data: 8'hA5, pe: 1'b1, pt: 1'b1, exp_par: 1'b1, exp_len: 11};
        vecs[2] = '{data: 8'hA5, pe: 1'b0, pt: 1'b0, exp_par: 1'b0, exp_len: 10};
        vecs[3] = '{data: 8'h3C, pe: 1'b1, pt: 1'b0, exp_par: 1'b0, exp_len: 11};
        vecs[4] = '{data: 8'h01, pe: 1'b1, pt: 1'b0, exp_par: 1'b1, exp_len: 11};
        vecs[5] = '{data: 8'h01, pe: 1'b1, pt: 1'b1, exp_par: 1'b0, exp_len: 11};
        vecs[6] = '{data: 8'hFF, pe: 1'b0, pt: 1'b1, exp_par: 1'b1, exp_len: 10};
        vecs[7] = '{data: 8'h00, pe: 1'b1, pt: 1'b1, exp_par: 1'b1, exp_len: 11};
        vecs[8] = '{data: 8'h80, pe: 1'b1, pt: 1'b0, exp_par: 1'b1, exp_len: 11};

        rst        = 1'b0;
        p_data     = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_typ    = 1'b0;

        // Reset values and quiet idle after release
        repeat (2) @(negedge clk);
        check("rst_mux_sel", 8'(mux_sel), 8'(2'b01));
        check("rst_busy", 8'(busy), 8'(0));
        check("rst_ser_data", 8'(ser_data), 8'(0));
        check("rst_par_bit", 8'(par_bit), 8'(0));
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_mux_sel", 8'(mux_sel), 8'(2'b01));
            check("idle_busy", 8'(busy), 8'(0));
        end

        for (int i = 0; i < 9; i++) run_frame(vecs[i]);

        // Back-to-back: DATA_VALID held high, second byte presented during frame 1
        p_data     = 8'h3C;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        push_frame(8'h3C, 1'b1, 1'b0, 1'b0);
        push_frame(8'hC3, 1'b1, 1'b0, 1'b1);
        step();
        p_data = 8'hC3;
        for (int i = 0; i < 10; i++) step();
        step();
        check("b2b_no_gap_sel", 8'(mux_sel), 8'(2'b00));
        data_valid = 1'b0;
        for (int i = 0; i < 11; i++) step();
        check("b2b_queue_drained", 8'(exp_q.size()), 8'(0));

        // Mid-frame DATA_VALID pulse and input changes are ignored
        p_data     = 8'hA5;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        push_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        p_data     = 8'h5A;
        par_en     = 1'b0;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        check("midframe_queue_drained", 8'(exp_q.size()), 8'(0));
        step();
        check("midframe_no_restart", 8'(mux_sel), 8'(2'b01));

        // Reset asserted during the 4th data bit aborts the frame immediately
        p_data     = 8'hFF;
        par_en     = 1'b1;
        par_typ    = 1'b0;
        data_valid = 1'b1;
        push_frame(8'hFF, 1'b1, 1'b0, 1'b1);
        step();
        data_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_in_data", 8'(mux_sel), 8'(2'b10));
        #2 rst = 1'b0;
        #1;
        check("abort_mux_sel", 8'(mux_sel), 8'(2'b01));
        check("abort_busy", 8'(busy), 8'(0));
        check("abort_ser_data", 8'(ser_data), 8'(0));
        check("abort_par_bit", 8'(par_bit), 8'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 8'(mux_sel), 8'(2'b01));
        run_frame('{data: 8'h5A, pe: 1'b1, pt: 1'b1, exp_par: 1'b1, exp_len: 11});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
